// File: rtl/xor_parity_tx.sv
// Serial parity-framing transmitter.
// Each accepted word is shifted out LSB first, one bit per accepted beat, and the frame ends
// with one parity beat. The parity beat is the XOR of all data bits, inverted when PARITY_ODD
// is set.
module xor_parity_tx #(
    parameter int unsigned WIDTH      = 32,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx_bit,
    output logic             tx_valid,
    output logic             tx_last,
    input  logic             tx_ready,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             acc_q, acc_d;

    // Frame sequencing: load on accept, shift per accepted data beat, then one parity beat.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    shreg_d = in_data;
                    cnt_d   = '0;
                    acc_d   = PARITY_ODD;
                    state_d = StData;
                end
            end
            StData: begin
                if (tx_ready) begin
                    acc_d   = acc_q ^ shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    // Hold the counter on the final beat so it never wraps inside a frame.
                    if (cnt_q == LastCnt) begin
                        state_d = StParity;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (tx_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    // Outputs decode registered state only; no path from in_valid or tx_ready.
    always_comb begin
        tx_bit   = 1'b0;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        unique case (state_q)
            StData: begin
                tx_bit   = shreg_q[0];
                tx_valid = 1'b1;
            end
            StParity: begin
                tx_bit   = acc_q;
                tx_valid = 1'b1;
                tx_last  = 1'b1;
            end
            default: ;
        endcase
        in_ready = (state_q == StIdle);
        busy     = (state_q != StIdle);
    end

endmodule

// File: tb/tb_xor_parity_tx.sv
// Directed bench for xor_parity_tx: an even-parity and an odd-parity instance, each checked
// beat by beat against a queue of expected {last, bit} pairs filled when a word is sent.
module tb_xor_parity_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          accept_cyc = 0;

    logic [31:0] e_in_data = '0, o_in_data = '0;
    logic        e_in_valid = 1'b0, o_in_valid = 1'b0;
    logic        e_tx_ready = 1'b1, o_tx_ready = 1'b1;
    logic        e_in_ready, e_tx_bit, e_tx_valid, e_tx_last, e_busy;
    logic        o_in_ready, o_tx_bit, o_tx_valid, o_tx_last, o_busy;

    logic [1:0]  q_e[$];
    logic [1:0]  q_o[$];

    xor_parity_tx #(.WIDTH(32), .PARITY_ODD(1'b0)) dut_e (
        .clk(clk), .rst(rst), .in_data(e_in_data), .in_valid(e_in_valid),
        .in_ready(e_in_ready), .tx_bit(e_tx_bit), .tx_valid(e_tx_valid),
        .tx_last(e_tx_last), .tx_ready(e_tx_ready), .busy(e_busy)
    );

    xor_parity_tx #(.WIDTH(32), .PARITY_ODD(1'b1)) dut_o (
        .clk(clk), .rst(rst), .in_data(o_in_data), .in_valid(o_in_valid),
        .in_ready(o_in_ready), .tx_bit(o_tx_bit), .tx_valid(o_tx_valid),
        .tx_last(o_tx_last), .tx_ready(o_tx_ready), .busy(o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every beat the DUT hands over is popped and compared.
    always @(negedge clk) begin
        logic [1:0] exp;
        if (!rst && e_tx_valid && e_tx_ready) begin
            tests++;
            assert (q_e.size() > 0) else begin
                fails++;
                $error("FAIL e_extra_beat observed bit=%0b last=%0b required no beat",
                       e_tx_bit, e_tx_last);
            end
            if (q_e.size() > 0) begin
                exp = q_e.pop_front();
                tests++;
                assert ({e_tx_last, e_tx_bit} === exp) else begin
                    fails++;
                    $error("FAIL e_beat observed last/bit=%b required %b", {e_tx_last, e_tx_bit}, exp);
                end
            end
        end
        if (!rst && o_tx_valid && o_tx_ready) begin
            tests++;
            assert (q_o.size() > 0) else begin
                fails++;
                $error("FAIL o_extra_beat observed bit=%0b last=%0b required no beat",
                       o_tx_bit, o_tx_last);
            end
            if (q_o.size() > 0) begin
                exp = q_o.pop_front();
                tests++;
                assert ({o_tx_last, o_tx_bit} === exp) else begin
                    fails++;
                    $error("FAIL o_beat observed last/bit=%b required %b", {o_tx_last, o_tx_bit}, exp);
                end
            end
        end
    end

    task automatic check(input string tag, input logic obs, input logic req);
        tests++;
        assert (obs === req) else begin
            fails++;
            $error("FAIL %s observed=%0b required=%0b", tag, obs, req);
        end
    endtask

    // Queue the expected frame, then hold in_valid until the word is accepted.
    task automatic send(input bit odd, input logic [31:0] d);
        int n = 0;
        logic par = (^d) ^ odd;
        for (int i = 0; i < 32; i++) begin
            if (odd) q_o.push_back({1'b0, d[i]});
            else     q_e.push_back({1'b0, d[i]});
        end
        if (odd) q_o.push_back({1'b1, par});
        else     q_e.push_back({1'b1, par});
        if (odd) begin o_in_data = d; o_in_valid = 1'b1; end
        else     begin e_in_data = d; e_in_valid = 1'b1; end
        while (!(odd ? o_in_ready : e_in_ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        assert (n < 200) else begin
            fails++;
            $error("FAIL accept_timeout observed waited=%0d required <200", n);
        end
        @(posedge clk); #1;
        accept_cyc = cyc;
        if (odd) o_in_valid = 1'b0;
        else     e_in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit odd);
        int n = 0;
        while (((odd ? q_o.size() : q_e.size()) != 0 || (odd ? o_busy : e_busy)) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        assert (n < 300) else begin
            fails++;
            $error("FAIL frame_timeout observed left=%0d required 0",
                   odd ? q_o.size() : q_e.size());
        end
    endtask

    initial begin
        int first;
        logic [31:0] a5 = 32'hA5A5_A5A5;
        logic hb, hl, hv;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_valid", e_tx_valid, 1'b0);
        check("rst_tx_last", e_tx_last, 1'b0);
        check("rst_tx_bit", e_tx_bit, 1'b0);
        check("rst_busy", e_busy, 1'b0);
        check("rst_in_ready", e_in_ready, 1'b1);
        check("rst_o_tx_valid", o_tx_valid, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // All-zero word, then back-to-back accept to measure frame spacing
        send(1'b0, 32'h0000_0000);
        first = accept_cyc;
        check("first_beat_valid", e_tx_valid, 1'b1);
        check("busy_in_frame", e_busy, 1'b1);
        send(1'b0, 32'h0000_0001);
        tests++;
        assert ((accept_cyc - first) === 34) else begin
            fails++;
            $error("FAIL accept_spacing observed=%0d required=34", accept_cyc - first);
        end
        wait_done(1'b0);
        send(1'b0, 32'hFFFF_FFFF);
        wait_done(1'b0);

        // Odd parity instance
        send(1'b1, 32'h0000_0000);
        wait_done(1'b1);
        send(1'b1, 32'h8000_0000);
        wait_done(1'b1);

        // Backpressure on beat 5 and on the parity beat
        send(1'b0, a5);
        repeat (5) @(posedge clk);
        #1;
        e_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall_data_bit", e_tx_bit, a5[5]);
            check("stall_data_valid", e_tx_valid, 1'b1);
            check("stall_data_last", e_tx_last, 1'b0);
        end
        e_tx_ready = 1'b1;
        repeat (27) @(posedge clk);
        #1;
        e_tx_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("stall_par_bit", e_tx_bit, 1'b0);
            check("stall_par_valid", e_tx_valid, 1'b1);
            check("stall_par_last", e_tx_last, 1'b1);
        end
        e_tx_ready = 1'b1;
        wait_done(1'b0);

        // in_valid during DATA is ignored
        send(1'b0, 32'h0F0F_0001);
        repeat (3) @(posedge clk);
        #1;
        e_in_data  = 32'h1234_5678;
        e_in_valid = 1'b1;
        check("ignore_in_ready", e_in_ready, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("ignore_busy", e_busy, 1'b1);
        check("ignore_in_ready2", e_in_ready, 1'b0);
        e_in_valid = 1'b0;
        wait_done(1'b0);
        send(1'b0, 32'h1234_5678);
        wait_done(1'b0);

        // Reset mid-frame at beat 10: outputs drop without a clock edge
        send(1'b0, 32'hDEAD_BEEF);
        repeat (10) @(posedge clk);
        #1;
        hv = e_tx_valid;
        check("pre_abort_valid", hv, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_tx_valid", e_tx_valid, 1'b0);
        check("abort_tx_last", e_tx_last, 1'b0);
        check("abort_busy", e_busy, 1'b0);
        check("abort_in_ready", e_in_ready, 1'b1);
        q_e.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(1'b0, 32'h0000_0003);
        wait_done(1'b0);
        hb = e_tx_bit;
        hl = e_tx_last;
        check("idle_tx_bit", hb, 1'b0);
        check("idle_tx_last", hl, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
